// File: rtl/bp_pkg.sv
// Shared branch-predictor types and saturating-counter helpers.
// Counter helpers take the counter width as an argument so one package serves every table size.
package bp_pkg;

  localparam int CTR_W_DEF  = 3;
  localparam int HIST_W_DEF = 10;
  localparam int CTR_W_MAX  = 16;

  typedef logic [CTR_W_DEF-1:0]  ctr_t;
  typedef logic [HIST_W_DEF-1:0] hist_t;
  typedef logic [CTR_W_MAX-1:0]  ctr_wide_t;

  typedef enum logic {INIT, RUN} state_t;

  function automatic ctr_wide_t ctr_max(input int w);
    return ctr_wide_t'((32'd1 << w) - 32'd1);
  endfunction

  function automatic ctr_wide_t sat_inc(input ctr_wide_t c, input int w);
    return (c >= ctr_max(w)) ? c : c + ctr_wide_t'(1);
  endfunction

  function automatic ctr_wide_t sat_dec(input ctr_wide_t c);
    return (c == '0) ? c : c - ctr_wide_t'(1);
  endfunction

  // Weakly not-taken: one below the MSB-set midpoint.
  function automatic ctr_wide_t ctr_init(input int w);
    return ctr_wide_t'((32'd1 << (w - 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/local_predictor_param_if.sv
// Predict/update port bundle between fetch logic and the local predictor.
interface local_predictor_param_if #(
  parameter int PC_W   = 10,
  parameter int HIST_W = 10
);
  logic              ready;
  logic              pred_valid;
  logic [PC_W-1:0]   pred_pc;
  logic              pred_out_valid;
  logic              pred_taken;
  logic [HIST_W-1:0] pred_hist;
  logic              upd_valid;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_taken;
  logic [HIST_W-1:0] upd_hist;

  modport master (
    input  ready, pred_out_valid, pred_taken, pred_hist,
    output pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, upd_hist
  );

  modport slave (
    output ready, pred_out_valid, pred_taken, pred_hist,
    input  pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, upd_hist
  );
endinterface

// File: rtl/sat_counter_table.sv
// Table of saturating counters with single-cycle read-modify-write update,
// a sweep-init write port and a write-first bypassed read port.
module sat_counter_table
  import bp_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CTR_W  = 3
) (
  input  logic              clock,
  input  logic              init_en,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CTR_W-1:0]  rd_ctr
);

  localparam int DEPTH = 1 << ADDR_W;

  if (CTR_W < 2 || CTR_W > CTR_W_MAX) begin : g_bad_ctr_w
    $error("sat_counter_table: CTR_W out of range");
  end

  logic [CTR_W-1:0] mem [DEPTH];
  logic [CTR_W-1:0] upd_cur;
  logic [CTR_W-1:0] upd_next;

  always_comb begin
    upd_cur  = mem[upd_addr];
    upd_next = upd_taken ? CTR_W'(sat_inc(ctr_wide_t'(upd_cur), CTR_W))
                         : CTR_W'(sat_dec(ctr_wide_t'(upd_cur)));
    rd_ctr   = (upd_en && (upd_addr == rd_addr)) ? upd_next : mem[rd_addr];
  end

  always_ff @(posedge clock) begin
    if (init_en) begin
      mem[init_addr] <= CTR_W'(ctr_init(CTR_W));
    end else if (upd_en) begin
      mem[upd_addr] <= upd_next;
    end
  end

endmodule

// File: rtl/local_predictor_param.sv
// Two-level local branch predictor: per-PC history table indexing a table of
// saturating counters, two-stage predict pipeline, sweep-initialised tables.
module local_predictor_param
  import bp_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int LHT_IDX_W = 10,
  parameter int HIST_W    = 10,
  parameter int CTR_W     = 3
) (
  input logic                    clock,
  input logic                    reset,
  local_predictor_param_if.slave bus
);

  localparam int SWEEP_W   = (LHT_IDX_W > HIST_W) ? LHT_IDX_W : HIST_W;
  localparam int LHT_DEPTH = 1 << LHT_IDX_W;
  localparam int LPT_DEPTH = 1 << HIST_W;

  if (PC_W < LHT_IDX_W) begin : g_bad_pc_w
    $error("local_predictor_param: PC_W must be >= LHT_IDX_W");
  end
  if (HIST_W < 2) begin : g_bad_hist_w
    $error("local_predictor_param: HIST_W must be >= 2");
  end

  state_t               state;
  logic [SWEEP_W-1:0]   cnt;
  logic                 ready_q;
  logic [HIST_W-1:0]    lht [LHT_DEPTH];

  logic                 pred_fire;
  logic                 upd_fire;
  logic [LHT_IDX_W-1:0] pred_idx;
  logic [LHT_IDX_W-1:0] upd_idx;
  logic [HIST_W-1:0]    upd_hist_new;
  logic                 init_lht_en;
  logic                 init_lpt_en;
  logic                 unused_pc;

  logic [HIST_W-1:0]    hist_p0;
  logic                 vld_p1;
  logic [HIST_W-1:0]    hist_p1;
  logic [CTR_W-1:0]     ctr_p1;
  logic                 vld_p2;
  logic                 taken_p2;
  logic [HIST_W-1:0]    hist_p2;

  assign pred_fire    = ready_q && bus.pred_valid;
  assign upd_fire     = ready_q && bus.upd_valid;
  assign pred_idx     = bus.pred_pc[LHT_IDX_W-1:0];
  assign upd_idx      = bus.upd_pc[LHT_IDX_W-1:0];
  assign upd_hist_new = {bus.upd_hist[HIST_W-2:0], bus.upd_taken};
  assign init_lht_en  = (state == INIT) && (32'(cnt) < LHT_DEPTH);
  assign init_lpt_en  = (state == INIT) && (32'(cnt) < LPT_DEPTH);
  assign unused_pc    = ^{bus.pred_pc, bus.upd_pc};

  // Sweep both tables once after reset; the arrays themselves are never reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= INIT;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + SWEEP_W'(1);
          if (&cnt) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN:     ready_q <= 1'b1;
        default: state   <= INIT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (init_lht_en) begin
      lht[cnt[LHT_IDX_W-1:0]] <= '0;
    end else if (upd_fire) begin
      lht[upd_idx] <= upd_hist_new;
    end
  end

  // S1: history lookup, write-first against a same-cycle update
  always_comb begin
    hist_p0 = lht[pred_idx];
    if (upd_fire && (upd_idx == pred_idx)) hist_p0 = upd_hist_new;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) vld_p1 <= 1'b0;
    else        vld_p1 <= pred_fire;
  end

  always_ff @(posedge clock) begin
    hist_p1 <= hist_p0;
  end

  // S2: counter lookup, bypassed inside the table
  sat_counter_table #(
    .ADDR_W (HIST_W),
    .CTR_W  (CTR_W)
  ) u_lpt (
    .clock     (clock),
    .init_en   (init_lpt_en),
    .init_addr (cnt[HIST_W-1:0]),
    .upd_en    (upd_fire),
    .upd_addr  (bus.upd_hist),
    .upd_taken (bus.upd_taken),
    .rd_addr   (hist_p1),
    .rd_ctr    (ctr_p1)
  );

  // Output stage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p2   <= 1'b0;
      taken_p2 <= 1'b0;
      hist_p2  <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        taken_p2 <= ctr_p1[CTR_W-1];
        hist_p2  <= hist_p1;
      end
    end
  end

  assign bus.ready          = ready_q;
  assign bus.pred_out_valid = vld_p2;
  assign bus.pred_taken     = taken_p2;
  assign bus.pred_hist      = hist_p2;

endmodule

// File: tb/tb_local_predictor_param.sv
// Scoreboard bench for local_predictor_param: directed and random traffic against
// an array-based model of the history and counter tables.
module tb_local_predictor_param;

  localparam int PC_W      = 12;
  localparam int LHT_IDX_W = 10;
  localparam int HIST_W    = 10;
  localparam int CTR_W     = 3;
  localparam int LHT_N     = 1 << LHT_IDX_W;
  localparam int LPT_N     = 1 << HIST_W;
  localparam int CTR_MAX   = (1 << CTR_W) - 1;
  localparam int CTR_INIT  = (1 << (CTR_W - 1)) - 1;
  localparam int INIT_CYC  = (LHT_N > LPT_N) ? LHT_N : LPT_N;

  logic clock = 1'b0;
  logic reset = 1'b1;

  local_predictor_param_if #(.PC_W(PC_W), .HIST_W(HIST_W)) bus ();

  local_predictor_param #(
    .PC_W      (PC_W),
    .LHT_IDX_W (LHT_IDX_W),
    .HIST_W    (HIST_W),
    .CTR_W     (CTR_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic              taken;
    logic [HIST_W-1:0] hist;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   lht_m [LHT_N];
  int   lpt_m [LPT_N];
  bit   pend_v;
  int   pend_h;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LHT_N; i++) lht_m[i] = 0;
    for (int i = 0; i < LPT_N; i++) lpt_m[i] = CTR_INIT;
    pend_v = 1'b0;
    pend_h = 0;
    sbq.delete();
  endtask

  task automatic idle_inputs();
    bus.pred_valid = 1'b0;
    bus.pred_pc    = '0;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_taken  = 1'b0;
    bus.upd_hist   = '0;
  endtask

  function automatic int rnd_pc();
    return $urandom_range(0, 31) | ($urandom_range(0, 3) << 10);
  endfunction

  // One accepted cycle: the update happens first (write-first), a prediction
  // reads history now and its counter one cycle later.
  task automatic step(input bit pv, input int ppc, input bit uv, input int upc,
                      input bit ut, input int uh);
    exp_t e;
    bus.pred_valid = pv;
    bus.pred_pc    = PC_W'(ppc);
    bus.upd_valid  = uv;
    bus.upd_pc     = PC_W'(upc);
    bus.upd_taken  = ut;
    bus.upd_hist   = HIST_W'(uh);
    if (uv) begin
      lht_m[upc % LHT_N] = ((uh * 2) + (ut ? 1 : 0)) % LPT_N;
      if (ut) lpt_m[uh % LPT_N] = (lpt_m[uh % LPT_N] < CTR_MAX) ? lpt_m[uh % LPT_N] + 1 : CTR_MAX;
      else    lpt_m[uh % LPT_N] = (lpt_m[uh % LPT_N] > 0) ? lpt_m[uh % LPT_N] - 1 : 0;
    end
    if (pend_v) begin
      e.taken = (lpt_m[pend_h] >= (1 << (CTR_W - 1)));
      e.hist  = HIST_W'(pend_h);
      sbq.push_back(e);
    end
    pend_v = pv;
    if (pv) pend_h = lht_m[ppc % LHT_N];
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input bit junk, output int n);
    n = 0;
    while (!bus.ready && n < 3000) begin
      if (junk) begin
        bus.pred_valid = 1'($urandom_range(0, 1));
        bus.pred_pc    = PC_W'(rnd_pc());
        bus.upd_valid  = 1'($urandom_range(0, 1));
        bus.upd_pc     = PC_W'(rnd_pc());
        bus.upd_taken  = 1'($urandom_range(0, 1));
        bus.upd_hist   = HIST_W'($urandom_range(0, 31));
      end else begin
        idle_inputs();
      end
      @(posedge clock);
      #1;
      n++;
    end
    idle_inputs();
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset && bus.pred_out_valid) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL pred_unexpected: got taken=%0b hist=%0h, want no output",
                 bus.pred_taken, bus.pred_hist);
      end else begin
        e = sbq.pop_front();
        if (bus.pred_taken !== e.taken || bus.pred_hist !== e.hist) begin
          bad++;
          $display("FAIL pred_out: got taken=%0b hist=%0h want taken=%0b hist=%0h",
                   bus.pred_taken, bus.pred_hist, e.taken, e.hist);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    idle_inputs();
    model_reset();

    #2 reset = 1'b0;
    #1;
    chk("rst_ready", bus.ready, 0);
    chk("rst_pred_out_valid", bus.pred_out_valid, 0);
    chk("rst_pred_taken", bus.pred_taken, 0);
    chk("rst_pred_hist", bus.pred_hist, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    wait_ready(1'b1, n);
    chk("init_latency", n, INIT_CYC);

    // First prediction on freshly swept tables
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // One taken update, then predictions through the new counter and history
    step(0, 0, 1, 5, 1, 0);
    step(1, 6, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Saturate high then low on back-to-back updates
    for (int i = 0; i < 8; i++) step(0, 0, 1, 20, 1, 0);
    step(1, 6, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 21, 0, 0);
    step(1, 6, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // History bypass: update and predict the same PC in one cycle
    step(1, 9, 1, 9, 1, 3);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Counter bypass: update lands in the cycle the counter is read
    for (int i = 0; i < 3; i++) step(0, 0, 1, 22, 1, 0);
    step(1, 30, 0, 0, 0, 0);
    step(0, 0, 1, 40, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Back-to-back predictions
    step(1, 1, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0, rnd_pc(), 1'($urandom_range(0, 1)), rnd_pc(),
           1'($urandom_range(0, 1)), $urandom_range(0, 31));
    end
    repeat (3) step(0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", sbq.size(), 0);

    // Reset with predictions in flight
    step(1, 7, 1, 7, 1, 5);
    step(1, 8, 0, 0, 0, 0);
    #1 reset = 1'b0;
    #1;
    chk("midrun_rst_ready", bus.ready, 0);
    chk("midrun_rst_pred_out_valid", bus.pred_out_valid, 0);
    chk("midrun_rst_pred_taken", bus.pred_taken, 0);
    chk("midrun_rst_pred_hist", bus.pred_hist, 0);
    model_reset();
    idle_inputs();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Reset again partway through the sweep
    repeat (500) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("init_rst_ready", bus.ready, 0);
    chk("init_rst_pred_out_valid", bus.pred_out_valid, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    wait_ready(1'b0, n);
    chk("reinit_latency", n, INIT_CYC);

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 1) != 0, rnd_pc(), 1'($urandom_range(0, 1)), rnd_pc(),
           1'($urandom_range(0, 1)), $urandom_range(0, 31));
    end
    repeat (3) step(0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained_after_reinit", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
